// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
//
// Quadrature encoder decoder with a position counter. The asynchronous A/B
// phases go through 2-flop synchronizers. Optionally they then go through a
// per-phase glitch filter, built only when QDEC_FILTER_EN is defined. The
// result is decoded against the previous sample into up, down, idle or
// illegal steps.
//
// Configuration macro:
//   QDEC_FILTER_EN - when defined, each synchronized phase changes its
//                    filtered value only after FILTER_LEN consecutive
//                    identical samples.
//
// Parameters:
//   WIDTH      - width of d_in and count
//   FILTER_LEN - stable-sample count of the glitch filter (filter builds only)
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   enable   in   count enable (0 holds count and dir, suppresses step)
//   load     in   synchronous load of d_in into count (wins over a step)
//   d_in     in   load value
//   a_in     in   asynchronous quadrature phase A
//   b_in     in   asynchronous quadrature phase B
//   err_clr  in   clears err (an illegal transition in the same cycle wins)
//   count    out  position counter
//   dir      out  direction of the last counted step (1 = up)
//   step     out  one-cycle pulse per counted step
//   err      out  sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_decoder #(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_UP      = 2'b01;
    localparam logic [1:0] TR_DOWN    = 2'b10;
    localparam logic [1:0] TR_ILLEGAL = 2'b11;

    // Classify a {prev, cur} phase pair; the up cycle is 00->01->11->10->00.
    function automatic logic [1:0] classify(input logic [1:0] prev_ab,
                                            input logic [1:0] cur_ab);
        logic [1:0] res;
        case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: res = TR_UP;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: res = TR_DOWN;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: res = TR_ILLEGAL;
            default:                            res = TR_IDLE;
        endcase
        return res;
    endfunction

    logic             a_meta_r;
    logic             a_sync_r;
    logic             b_meta_r;
    logic             b_sync_r;
    logic [1:0]       ab_s;
    logic [1:0]       dec_ab_s;

    logic [0:0]       state_r;
    logic [1:0]       prev_ab_r;

    logic [WIDTH-1:0] count_r;
    logic             dir_r;
    logic             step_r;
    logic             err_r;

    logic [1:0]       tr_s;
    logic             valid_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic             dir_nxt_s;
    logic             err_nxt_s;

    assign ab_s = {a_sync_r, b_sync_r};

    // Two-flop synchronizers for the asynchronous encoder phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta_r <= 1'b0;
            a_sync_r <= 1'b0;
            b_meta_r <= 1'b0;
            b_sync_r <= 1'b0;
        end else begin
            a_meta_r <= a_in;
            a_sync_r <= a_meta_r;
            b_meta_r <= b_in;
            b_sync_r <= b_meta_r;
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int             FCW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [FCW-1:0] F_ONE  = FCW'(1);
    // The pipeline holds valid pin data once the synchronizers and the filter
    // have both seen the pins.
    localparam int             SETTLE_LEN = 2 + FILTER_LEN;

    logic           a_filt_r;
    logic           b_filt_r;
    logic [FCW-1:0] a_fcnt_r;
    logic [FCW-1:0] b_fcnt_r;

    // Glitch filters: a phase follows its synchronized value only after it has
    // differed for FILTER_LEN consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_filt_r <= 1'b0;
            b_filt_r <= 1'b0;
            a_fcnt_r <= '0;
            b_fcnt_r <= '0;
        end else begin
            if (a_sync_r == a_filt_r) begin
                a_fcnt_r <= '0;
            end else if (a_fcnt_r == F_LAST) begin
                a_filt_r <= a_sync_r;
                a_fcnt_r <= '0;
            end else begin
                a_fcnt_r <= a_fcnt_r + F_ONE;
            end
            if (b_sync_r == b_filt_r) begin
                b_fcnt_r <= '0;
            end else if (b_fcnt_r == F_LAST) begin
                b_filt_r <= b_sync_r;
                b_fcnt_r <= '0;
            end else begin
                b_fcnt_r <= b_fcnt_r + F_ONE;
            end
        end
    end

    assign dec_ab_s = {a_filt_r, b_filt_r};
`else
    // Filter absent: FILTER_LEN deliberately has no effect on this build.
    localparam int SETTLE_LEN = 2 + 0 * FILTER_LEN;

    assign dec_ab_s = ab_s;
`endif

    localparam int            SW          = $clog2(SETTLE_LEN + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

    logic [SW-1:0] settle_r;

    // Tracking FSM. INIT keeps sampling the decoder input without decoding it
    // until the reset-cleared input pipeline reflects the real pins, so a
    // release with the encoder away from 00 gives no spurious err or step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_INIT;
            prev_ab_r <= 2'b00;
            settle_r  <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    prev_ab_r <= dec_ab_s;
                    if (settle_r == SETTLE_LAST) begin
                        state_r <= ST_TRACK;
                    end else begin
                        settle_r <= settle_r + SETTLE_ONE;
                    end
                end
                ST_TRACK: begin
                    prev_ab_r <= dec_ab_s;
                end
                default: begin
                    state_r   <= ST_INIT;
                    prev_ab_r <= dec_ab_s;
                    settle_r  <= '0;
                end
            endcase
        end
    end

    // Next-state values for the counter, direction, step pulse and error flag.
    always_comb begin
        tr_s        = TR_IDLE;
        valid_s     = 1'b0;
        count_nxt_s = count_r;
        dir_nxt_s   = dir_r;
        err_nxt_s   = err_r;

        if (state_r == ST_TRACK) begin
            tr_s = classify(prev_ab_r, dec_ab_s);
        end else begin
            tr_s = TR_IDLE;
        end

        // A step counts only when enabled and not overridden by a load.
        if (enable && !load && ((tr_s == TR_UP) || (tr_s == TR_DOWN))) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end

        if (load) begin
            count_nxt_s = d_in;
        end else if (valid_s && (tr_s == TR_UP)) begin
            count_nxt_s = count_r + WIDTH'(1);
        end else if (valid_s) begin
            count_nxt_s = count_r - WIDTH'(1);
        end else begin
            count_nxt_s = count_r;
        end

        if (valid_s) begin
            dir_nxt_s = (tr_s == TR_UP);
        end else begin
            dir_nxt_s = dir_r;
        end

        // An illegal transition wins over a simultaneous clear.
        if (tr_s == TR_ILLEGAL) begin
            err_nxt_s = 1'b1;
        end else if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            dir_r   <= 1'b0;
            step_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            dir_r   <= dir_nxt_s;
            step_r  <= valid_s;
            err_r   <= err_nxt_s;
        end
    end

    assign count = count_r;
    assign dir   = dir_r;
    assign step  = step_r;
    assign err   = err_r;

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
//
// Directed self-checking bench for quad_decoder (WIDTH=8). Inputs are driven
// on the falling clock edge and outputs are sampled on falling edges. Every
// expected value is hand-computed from the quadrature rules.
// With QDEC_FILTER_EN defined, the pin-to-count latency grows from 3 to 6
// clocks, and a glitch-rejection check is added.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

    localparam int WIDTH = 8;
`ifdef QDEC_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic             a_in;
    logic             b_in;
    logic             err_clr;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;

    int tests = 0;
    int fails = 0;

    logic [1:0] up_seq [4];

    quad_decoder #(
        .WIDTH      (WIDTH),
        .FILTER_LEN (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (load),
        .d_in    (d_in),
        .a_in    (a_in),
        .b_in    (b_in),
        .err_clr (err_clr),
        .count   (count),
        .dir     (dir),
        .step    (step),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new phase pair, then check the step window around the decode.
    task automatic do_step(input string tag, input logic [1:0] ab, input logic exp_step,
                           input logic [7:0] exp_count, input logic exp_dir);
        {a_in, b_in} = ab;
        tick(LAT - 1);
        check({tag, "/pre_step"}, 32'(step), 32'd0);
        tick(1);
        check({tag, "/step"}, 32'(step), 32'(exp_step));
        check({tag, "/count"}, 32'(count), 32'(exp_count));
        check({tag, "/dir"}, 32'(dir), 32'(exp_dir));
        tick(1);
        check({tag, "/step_end"}, 32'(step), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        d_in    = 8'h00;
        a_in    = 1'b0;
        b_in    = 1'b0;
        err_clr = 1'b0;
        up_seq  = '{2'b01, 2'b11, 2'b10, 2'b00};

        // Reset state
        tick(2);
        check("rst/count", 32'(count), 32'd0);
        check("rst/dir", 32'(dir), 32'd0);
        check("rst/step", 32'(step), 32'd0);
        check("rst/err", 32'(err), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(LAT + 4);

        // Full up cycle: count 0 -> 4
        for (int i = 0; i < 4; i++) begin
            do_step($sformatf("up%0d", i), up_seq[i], 1'b1, 8'(i + 1), 1'b1);
        end
        check("up/err", 32'(err), 32'd0);

        // Load then two down steps, wrapping through zero
        load = 1'b1;
        d_in = 8'h01;
        tick(1);
        load = 1'b0;
        check("load1/count", 32'(count), 32'h01);
        check("load1/step", 32'(step), 32'd0);
        do_step("down1", 2'b10, 1'b1, 8'h00, 1'b0);
        do_step("down2", 2'b11, 1'b1, 8'hFF, 1'b0);

        // Illegal 11->00
        {a_in, b_in} = 2'b00;
        tick(LAT);
        check("illegal/err", 32'(err), 32'd1);
        check("illegal/count", 32'(count), 32'hFF);
        check("illegal/step", 32'(step), 32'd0);
        tick(1);
        // Up wrap FF -> 00; err stays sticky
        do_step("wrap_up", 2'b01, 1'b1, 8'h00, 1'b1);
        check("sticky/err", 32'(err), 32'd1);
        // err_clr coincident with illegal 01->10: illegal wins
        {a_in, b_in} = 2'b10;
        tick(LAT - 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr_vs_illegal/err", 32'(err), 32'd1);
        check("clr_vs_illegal/count", 32'(count), 32'h00);
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr/err", 32'(err), 32'd0);

        // Disabled steps are tracked but not counted
        enable = 1'b0;
        do_step("dis0", 2'b00, 1'b0, 8'h00, 1'b1);
        do_step("dis1", 2'b01, 1'b0, 8'h00, 1'b1);
        do_step("dis2", 2'b11, 1'b0, 8'h00, 1'b1);
        enable = 1'b1;
        do_step("en", 2'b10, 1'b1, 8'h01, 1'b1);
        check("en/err", 32'(err), 32'd0);

        // Load coincident with a down step: load wins, dir held
        {a_in, b_in} = 2'b11;
        tick(LAT - 1);
        load = 1'b1;
        d_in = 8'h80;
        tick(1);
        load = 1'b0;
        check("load80/count", 32'(count), 32'h80);
        check("load80/step", 32'(step), 32'd0);
        check("load80/dir", 32'(dir), 32'd1);
        tick(1);
        check("load80/step_after", 32'(step), 32'd0);

        // Reset mid-step, release with the encoder at 11
        {a_in, b_in} = 2'b10;
        tick(1);
        rst_n = 1'b0;
        #1;
        check("midrst/count", 32'(count), 32'd0);
        check("midrst/dir", 32'(dir), 32'd0);
        check("midrst/step", 32'(step), 32'd0);
        check("midrst/err", 32'(err), 32'd0);
        {a_in, b_in} = 2'b11;
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check($sformatf("release%0d/step_err", i), 32'({step, err}), 32'd0);
        end
        check("release/count", 32'(count), 32'd0);
        do_step("post_rst", 2'b10, 1'b1, 8'h01, 1'b1);

`ifdef QDEC_FILTER_EN
        // Two-cycle glitch on a_in is rejected
        a_in = 1'b0;
        tick(2);
        a_in = 1'b1;
        tick(10);
        check("glitch/count", 32'(count), 32'h01);
        check("glitch/step", 32'(step), 32'd0);
        check("glitch/err", 32'(err), 32'd0);
        // A stable change is counted after 3 + 3 cycles
        do_step("filt", 2'b00, 1'b1, 8'h02, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
